// File: rtl/muldiv_ctrl_pkg.sv
// muldiv_ctrl_pkg
//   Shared types for the HI/LO multiply/divide sequencer: the operation
//   encoding seen from the execute stage, the sequencer state encoding, and
//   small decode helpers used by both the control and the datapath.
package muldiv_ctrl_pkg;

    typedef enum logic [1:0] {
        MD_MULT  = 2'd0,
        MD_MULTU = 2'd1,
        MD_DIV   = 2'd2,
        MD_DIVU  = 2'd3
    } muldiv_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } muldiv_state_t;

    function automatic logic op_is_div(input muldiv_op_t op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

    function automatic logic op_is_signed(input muldiv_op_t op);
        return (op == MD_MULT) || (op == MD_DIV);
    endfunction

endpackage

// File: rtl/muldiv_ctrl_if.sv
// muldiv_ctrl_if
//   Execute-stage <-> multiply/divide sequencer connection.
//   master (execute stage / hazard unit side):
//     out: start, op, a, b, flush
//     in : busy, done, hi_we, lo_we, hi, lo
//   slave (sequencer side): the same signals with directions reversed.
interface muldiv_ctrl_if #(
    parameter int DATA_W = 32
) ();
    import muldiv_ctrl_pkg::*;

    logic              start;
    muldiv_op_t        op;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic              flush;
    logic              busy;
    logic              done;
    logic              hi_we;
    logic              lo_we;
    logic [DATA_W-1:0] hi;
    logic [DATA_W-1:0] lo;

    modport master (
        output start, op, a, b, flush,
        input  busy, done, hi_we, lo_we, hi, lo
    );

    modport slave (
        input  start, op, a, b, flush,
        output busy, done, hi_we, lo_we, hi, lo
    );

endinterface

// File: rtl/muldiv_ctrl_div_step.sv
// muldiv_ctrl_div_step
//   One combinational restoring-division iteration.
//   acc_i     : {rem, quot} before the step
//   divisor_i : divisor magnitude
//   acc_o     : {rem, quot} after shift-left, trial subtract and, when the
//               subtract does not borrow, keeping the difference and setting
//               the new quotient LSB.
module muldiv_ctrl_div_step #(
    parameter int DATA_W = 32
) (
    input  logic [2*DATA_W-1:0] acc_i,
    input  logic [DATA_W-1:0]   divisor_i,
    output logic [2*DATA_W-1:0] acc_o
);
    // After the shift the partial remainder can be one bit wider than the
    // divisor, so the trial subtract is done at DATA_W+1 bits plus a borrow.
    logic [DATA_W:0]   rem_shift;
    logic [DATA_W+1:0] diff;
    logic              borrow;
    logic              unused_diff_msb;

    assign rem_shift = acc_i[2*DATA_W-1:DATA_W-1];
    assign diff      = {1'b0, rem_shift} - {2'b00, divisor_i};
    assign borrow    = diff[DATA_W+1];

    // A successful subtract leaves a remainder below the divisor, so the
    // top bit of the difference is always zero there.
    assign unused_diff_msb = diff[DATA_W];

    assign acc_o = borrow ? {acc_i[2*DATA_W-2:0], 1'b0}
                          : {diff[DATA_W-1:0], acc_i[DATA_W-2:0], 1'b1};

endmodule

// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl
//   Multi-cycle MULT/MULTU/DIV/DIVU sequencer for the HI/LO register pair.
//   Ports:
//     clk   : single clock, rising edge
//     reset : asynchronous, active-high; clears all state
//     bus   : muldiv_ctrl_if.slave
//             start/op/a/b/flush from execute; busy is the stall request,
//             done/hi_we/lo_we the one-cycle result pulse, hi/lo the result.
//   Every accepted operation runs 32 iterations (shift-add multiply or
//   restoring divide) on magnitudes, then sign-corrects on the way to DONE.
module muldiv_ctrl
    import muldiv_ctrl_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic            clk,
    input  logic            reset,
    muldiv_ctrl_if.slave    bus
);
    localparam int                CNT_W    = $clog2(DATA_W);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DATA_W - 1);

    muldiv_state_t       state_q, state_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic [2*DATA_W-1:0] acc_q, acc_d;      // product / {rem, quot}
    logic [DATA_W-1:0]   opnd_q, opnd_d;    // |multiplicand| or |divisor|
    logic [DATA_W-1:0]   a_q, a_d;          // raw rs, needed for divide by zero
    muldiv_op_t          op_q, op_d;
    logic                sa_q, sa_d;
    logic                sb_q, sb_d;
    logic                bzero_q, bzero_d;
    logic [DATA_W-1:0]   res_hi_q, res_hi_d; // result staged during DONE
    logic [DATA_W-1:0]   res_lo_q, res_lo_d;
    logic [DATA_W-1:0]   hi_q, hi_d;         // committed HI/LO
    logic [DATA_W-1:0]   lo_q, lo_d;

    // ---------------- operand conditioning ----------------
    logic              a_neg, b_neg;
    logic [DATA_W-1:0] a_mag, b_mag;

    always_comb begin
        a_neg = op_is_signed(bus.op) & bus.a[DATA_W-1];
        b_neg = op_is_signed(bus.op) & bus.b[DATA_W-1];
        a_mag = a_neg ? ({DATA_W{1'b0}} - bus.a) : bus.a;
        b_mag = b_neg ? ({DATA_W{1'b0}} - bus.b) : bus.b;
    end

    // ---------------- iteration datapath ----------------
    logic [DATA_W-1:0]   mul_addend;
    logic [DATA_W:0]     mul_sum;
    logic [2*DATA_W-1:0] mul_acc;
    logic [2*DATA_W-1:0] div_acc;
    logic [2*DATA_W-1:0] step_acc;

    // Multiplier sits in the low half and is consumed LSB first; the carry
    // out of the upper-half add becomes the new MSB after the right shift.
    always_comb begin
        mul_addend = acc_q[0] ? opnd_q : {DATA_W{1'b0}};
        mul_sum    = {1'b0, acc_q[2*DATA_W-1:DATA_W]} + {1'b0, mul_addend};
        mul_acc    = {mul_sum, acc_q[DATA_W-1:1]};
    end

    muldiv_ctrl_div_step #(
        .DATA_W    (DATA_W)
    ) u_div_step (
        .acc_i     (acc_q),
        .divisor_i (opnd_q),
        .acc_o     (div_acc)
    );

    assign step_acc = op_is_div(op_q) ? div_acc : mul_acc;

    // ---------------- sign fix-up of the final step ----------------
    logic [2*DATA_W-1:0] prod_fix;
    logic [DATA_W-1:0]   quot, rem;
    logic [DATA_W-1:0]   fix_hi, fix_lo;

    always_comb begin
        prod_fix = (sa_q ^ sb_q) ? ({(2*DATA_W){1'b0}} - step_acc) : step_acc;
        quot     = step_acc[DATA_W-1:0];
        rem      = step_acc[2*DATA_W-1:DATA_W];
        fix_hi   = prod_fix[2*DATA_W-1:DATA_W];
        fix_lo   = prod_fix[DATA_W-1:0];
        if (op_is_div(op_q)) begin
            if (bzero_q) begin
                fix_hi = a_q;
                fix_lo = {DATA_W{1'b1}};
            end else begin
                // Remainder takes the dividend's sign, quotient the xor.
                fix_hi = sa_q ? ({DATA_W{1'b0}} - rem) : rem;
                fix_lo = (sa_q ^ sb_q) ? ({DATA_W{1'b0}} - quot) : quot;
            end
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        acc_d    = acc_q;
        opnd_d   = opnd_q;
        a_d      = a_q;
        op_d     = op_q;
        sa_d     = sa_q;
        sb_d     = sb_q;
        bzero_d  = bzero_q;
        res_hi_d = res_hi_q;
        res_lo_d = res_lo_q;
        hi_d     = hi_q;
        lo_d     = lo_q;

        case (state_q)
            IDLE: begin
                if (bus.start && !bus.flush) begin
                    state_d = RUN;
                    count_d = '0;
                    op_d    = bus.op;
                    a_d     = bus.a;
                    sa_d    = a_neg;
                    sb_d    = b_neg;
                    bzero_d = (bus.b == '0);
                    // Upper half starts cleared; the low half holds the
                    // operand consumed by the loop (multiplier or dividend).
                    if (op_is_div(bus.op)) begin
                        opnd_d = b_mag;
                        acc_d  = {{DATA_W{1'b0}}, a_mag};
                    end else begin
                        opnd_d = a_mag;
                        acc_d  = {{DATA_W{1'b0}}, b_mag};
                    end
                end
            end
            RUN: begin
                if (bus.flush) begin
                    state_d = IDLE;
                end else begin
                    acc_d   = step_acc;
                    count_d = count_q + 1'b1;
                    if (count_q == CNT_LAST) begin
                        state_d  = DONE;
                        res_hi_d = fix_hi;
                        res_lo_d = fix_lo;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
                if (!bus.flush) begin
                    hi_d = res_hi_q;
                    lo_d = res_lo_q;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // ---------------- state registers ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            count_q  <= '0;
            acc_q    <= '0;
            opnd_q   <= '0;
            a_q      <= '0;
            op_q     <= MD_MULT;
            sa_q     <= 1'b0;
            sb_q     <= 1'b0;
            bzero_q  <= 1'b0;
            res_hi_q <= '0;
            res_lo_q <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            acc_q    <= acc_d;
            opnd_q   <= opnd_d;
            a_q      <= a_d;
            op_q     <= op_d;
            sa_q     <= sa_d;
            sb_q     <= sb_d;
            bzero_q  <= bzero_d;
            res_hi_q <= res_hi_d;
            res_lo_q <= res_lo_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
        end
    end

    // ---------------- outputs ----------------
    // A flush in the DONE cycle suppresses the pulse and keeps the old HI/LO
    // visible, so the new result is only shown while it is being committed.
    logic show_result;

    assign show_result = (state_q == DONE) & ~bus.flush;

    // Stall asserts in the issue cycle itself; gating with reset makes it
    // drop the moment reset is raised, regardless of start.
    assign bus.busy  = ~reset & ((state_q == RUN) |
                                 ((state_q == IDLE) & bus.start & ~bus.flush));
    assign bus.done  = show_result;
    assign bus.hi_we = show_result;
    assign bus.lo_we = show_result;
    assign bus.hi    = show_result ? res_hi_q : hi_q;
    assign bus.lo    = show_result ? res_lo_q : lo_q;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// tb_muldiv_ctrl
//   Directed bench for muldiv_ctrl: reset state, signed/unsigned multiply and
//   divide vectors, divide by zero, overflow, back-to-back issue, flush in
//   IDLE/RUN/DONE and reset in the middle of an operation.
module tb_muldiv_ctrl;
    import muldiv_ctrl_pkg::*;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;

    muldiv_ctrl_if #(.DATA_W(32)) bus ();

    muldiv_ctrl #(.DATA_W(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded its time budget");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Issue an op in the current (IDLE) cycle, which becomes cycle 0, and
    // follow it to cycle 34. With flush_done set, flush is raised in the DONE
    // cycle and exp_hi/exp_lo are the values that must survive.
    task automatic run_op(input string tag, input muldiv_op_t o,
                          input logic [31:0] av, input logic [31:0] bv,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                          input bit flush_done);
        bit run_ok;
        bus.op    = o;
        bus.a     = av;
        bus.b     = bv;
        bus.start = 1'b1;
        #1;
        check({tag, " busy c0"}, bus.busy, 1);
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.a     = 32'hDEADBEEF;   // operands must already be latched
        bus.b     = 32'h0BADF00D;
        run_ok    = 1'b1;
        for (int c = 1; c <= 32; c++) begin
            if (bus.busy !== 1'b1 || bus.done !== 1'b0) run_ok = 1'b0;
            if (c < 32) begin
                @(posedge clk); #1;
            end
        end
        check({tag, " busy/no-done c1..32"}, run_ok, 1);
        @(posedge clk); #1;
        if (flush_done) begin
            bus.flush = 1'b1;
            #1;
            check({tag, " flushed done c33"}, bus.done, 0);
            check({tag, " flushed hi_we c33"}, bus.hi_we, 0);
        end else begin
            check({tag, " done c33"}, bus.done, 1);
            check({tag, " we c33"}, {bus.hi_we, bus.lo_we}, 2'b11);
        end
        check({tag, " busy c33"}, bus.busy, 0);
        check({tag, " hi c33"}, bus.hi, exp_hi);
        check({tag, " lo c33"}, bus.lo, exp_lo);
        @(posedge clk); #1;
        bus.flush = 1'b0;
        #1;
        check({tag, " done c34"}, bus.done, 0);
        check({tag, " hi held c34"}, bus.hi, exp_hi);
        check({tag, " lo held c34"}, bus.lo, exp_lo);
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        reset     = 1'b1;
        bus.start = 1'b0;
        bus.op    = MD_MULT;
        bus.a     = '0;
        bus.b     = '0;
        bus.flush = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("reset busy", bus.busy, 0);
        check("reset done", bus.done, 0);
        check("reset we", {bus.hi_we, bus.lo_we}, 2'b00);
        check("reset hi", bus.hi, 0);
        check("reset lo", bus.lo, 0);
        reset = 1'b0;
        @(posedge clk); #1;

        // flush together with start in IDLE: start ignored
        bus.op    = MD_MULTU;
        bus.a     = 32'd9;
        bus.b     = 32'd9;
        bus.start = 1'b1;
        bus.flush = 1'b1;
        #1;
        check("idle flush busy", bus.busy, 0);
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.flush = 1'b0;
        #1;
        check("idle flush stays idle", bus.busy, 0);
        @(posedge clk); #1;

        // Main vectors, each started in the cycle after the previous result
        run_op("MULTU ffff*ffff", MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0);
        run_op("MULT -3*5",       MD_MULT,  32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0);
        run_op("DIV -7/2",        MD_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);
        run_op("DIV 7/-2",        MD_DIV,   32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0);
        run_op("DIVU 7/2",        MD_DIVU,  32'd7,        32'd2,        32'h00000001, 32'h00000003, 1'b0);
        run_op("DIV ovf",         MD_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0);
        run_op("DIVU 5/0",        MD_DIVU,  32'd5,        32'd0,        32'h00000005, 32'hFFFFFFFF, 1'b0);

        // Flush in cycle 10 of DIVU 100/3
        bus.op    = MD_DIVU;
        bus.a     = 32'd100;
        bus.b     = 32'd3;
        bus.start = 1'b1;
        #1;
        check("flush op busy c0", bus.busy, 1);
        for (int c = 1; c <= 10; c++) begin
            @(posedge clk); #1;
            bus.start = 1'b0;
        end
        bus.flush = 1'b1;
        #1;
        check("flush busy c10", bus.busy, 1);
        @(posedge clk); #1;
        bus.flush = 1'b0;
        #1;
        check("flush busy c11", bus.busy, 0);
        check("flush done c11", bus.done, 0);
        check("flush hi kept", bus.hi, 32'h00000005);
        check("flush lo kept", bus.lo, 32'hFFFFFFFF);
        @(posedge clk); #1;
        // Cycle 12: new op, result expected in cycle 45
        run_op("MULTU 2*3 after flush", MD_MULTU, 32'd2, 32'd3, 32'h00000000, 32'h00000006, 1'b0);

        // Flush in the DONE cycle: no pulse, HI/LO unchanged
        run_op("MULTU flush in DONE", MD_MULTU, 32'h00010000, 32'h00010000, 32'h00000000, 32'h00000006, 1'b1);
        run_op("MULTU 2^16*2^16",     MD_MULTU, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000, 1'b0);

        // Reset asserted in cycle 20 of an operation
        bus.op    = MD_DIV;
        bus.a     = 32'd1000;
        bus.b     = 32'd7;
        bus.start = 1'b1;
        #1;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk); #1;
            bus.start = 1'b0;
        end
        check("pre-reset busy c20", bus.busy, 1);
        reset = 1'b1;
        #1;
        check("mid-run reset busy", bus.busy, 0);
        check("mid-run reset done", bus.done, 0);
        check("mid-run reset hi", bus.hi, 0);
        check("mid-run reset lo", bus.lo, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        check("post-reset idle busy", bus.busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/muldiv_ctrl.md
# muldiv_ctrl

Multi-cycle multiply/divide sequencer serving the HI/LO register pair of the pipelined MIPS core. It accepts MULT/MULTU/DIV/DIVU from the execute stage and runs a 32-iteration shift-add or restoring-divide loop. It holds a stall request to the hazard unit while running, then pulses HI/LO write-enables with the 64-bit result. One operation is in flight at a time.

## Interface
Parameters:
- DATA_W, 32, operand width; iteration counter is $clog2(DATA_W) bits.

Ports:
- clk  in  1  the single clock; all state on rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- start  in  1  execute stage holds a valid mul/div instruction; sampled only in IDLE.
- op  in  muldiv_op_t  MD_MULT, MD_MULTU, MD_DIV, MD_DIVU.
- a  in  DATA_W  rs value (multiplicand / dividend), already forwarded.
- b  in  DATA_W  rt value (multiplier / divisor), already forwarded.
- flush  in  1  kill in-flight operation (exception/redirect).
- busy  out  1  stall request to the hazard unit.
- done  out  1  one-cycle result-valid pulse.
- hi_we, lo_we  out  1 each  equal to done.
- hi, lo  out  DATA_W each  result registers; hold the last result.

## Operation
- States: IDLE, RUN, DONE.
- IDLE, start=1, flush=0: latch |a|, |b| (magnitudes for signed ops, raw for unsigned), the sign flags and op; clear the accumulator and count; go RUN.
- RUN, multiply: each cycle, if multiplier LSB is 1 add the multiplicand into the upper half of the 64-bit accumulator, then shift the accumulator right by 1.
- RUN, divide: restoring step each cycle. Shift {rem, quot} left by 1, trial-subtract the divisor from rem; if there is no borrow, keep the difference and set the quotient LSB.
- RUN: count increments every cycle; at count=DATA_W-1, go DONE.
- RUN→DONE edge applies sign correction and registers hi/lo:
  - MULT: negate the 64-bit product if sa^sb.
  - DIV: negate quotient if sa^sb; negate remainder if sa.
- Divide by zero: result is forced to hi=a (original operand), lo=all-ones, for both DIV and DIVU. Latency is unchanged.
- DONE: done=1 for one cycle, then IDLE unconditionally.
- flush in RUN or DONE: next state IDLE; no done or write-enable is produced; hi/lo keep their previous value. flush in IDLE with start=1: start is ignored.
- start outside IDLE is ignored. The pipeline cannot issue a new op while busy.
- Reset: state=IDLE, count=0, accumulator=0, hi=lo=0, done=hi_we=lo_we=0, busy=0.

## Timing
- Cycle 0 is the cycle start is sampled in IDLE.
  - busy = (state==RUN) | (state==IDLE & start & ~flush), combinational, so the stall asserts in cycle 0.
- Cycles 1..32: RUN; busy=1.
- Cycle 33: DONE; busy=0, done=1, hi/lo valid. The stalled instruction advances at the end of cycle 33.
- Issue-to-result latency is 33 cycles for every op, including divide by zero.
- Back-to-back: the earliest next start is sampled in cycle 34 (IDLE).
- flush in cycle k (1≤k≤32): IDLE in cycle k+1 with busy=0. busy remains 1 in cycle k.
- Reset asserted mid-RUN: outputs reach reset values immediately, without waiting for a clock edge.

## Structure
- Shared package (common.svh): muldiv_op_t enum (MD_MULT, MD_MULTU, MD_DIV, MD_DIVU) and the muldiv_state_t enum.
- One natural combinational sub-module: div_step. It takes {rem, quot} and the divisor, and returns the shifted/subtracted {rem, quot}.
- Multiply step and sign fix-up stay inline.

## Test plan
- MULTU a=0xFFFFFFFF b=0xFFFFFFFF → cycle 33: done=1, hi=0xFFFFFFFE, lo=0x00000001; busy high in cycles 0–32 only.
- MULT a=0xFFFFFFFD (−3) b=5 → hi=0xFFFFFFFF, lo=0xFFFFFFF1.
- DIV a=0xFFFFFFF9 (−7) b=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIVU a=7 b=2 → lo=3, hi=1.
- DIVU a=5 b=0 → cycle 33: hi=5, lo=0xFFFFFFFF.
- DIV a=0x80000000 b=0xFFFFFFFF → lo=0x80000000, hi=0 (overflow wraps).
- Flush and reset:
  - DIVU 100/3 with flush in cycle 10 → no done; busy=0 in cycle 11; hi/lo unchanged.
  - MULTU 2×3 started in cycle 12 → result hi=0, lo=6, done in cycle 45.
  - reset asserted in cycle 20 of an operation → busy/done drop at once; hi=lo=0.
